// File: rtl/core_config_pkg.sv
// -----------------------------------------------------------------------------
// core_config_pkg
//   Core-wide configuration constants and shared types.
//
//   Reset sequencing content:
//     RST_TICK_CNT : default number of hold ticks after any reset event
//     RST_DOMAINS  : default number of sequenced reset domains
//     rst_cause_t  : encoding of the last reset cause (POR / SW / WDT)
//     seq_state_t  : reset sequencer FSM states
//     max_int()    : helper for sizing counters shared by several reload values
// -----------------------------------------------------------------------------
package core_config_pkg;

  // Cycles all domains are held after a reset event (hold lasts this + 1).
  localparam int RST_TICK_CNT = 8;

  // Domains sequenced by the reset sequencer: memory, regfile, pipeline, periph.
  localparam int RST_DOMAINS = 4;

  typedef enum logic [1:0] {
    RST_POR = 2'b00,
    RST_SW  = 2'b01,
    RST_WDT = 2'b10
  } rst_cause_t;

  typedef enum logic [1:0] {
    SEQ_HOLD  = 2'b00,
    SEQ_STAGE = 2'b01,
    SEQ_RUN   = 2'b10
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
//   Two-flop reset synchronizer: asynchronous assert, synchronous deassert.
//   The output drops the moment arst_n_i goes low and rises on the second
//   rising clock edge after arst_n_i returns high.
//
//   Ports:
//     clk_i    : clock of the destination domain
//     arst_n_i : raw asynchronous reset, active-low
//     rst_n_o  : synchronized reset, active-low
// -----------------------------------------------------------------------------
module rst_sync (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_n_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Sits between the board reset pin and the core reset inputs. After any
//   reset event all domains are held for HOLD_TICKS+1 cycles, then released
//   one at a time in ascending order. Each domain's stage ends when its
//   dom_ready is seen or after TIMEOUT_TICKS+1 cycles (recorded as a sticky
//   timeout). Software and watchdog requests re-enter the hold phase and
//   record the cause.
//
//   Ports:
//     clk          : system clock
//     rst_in       : external reset, active-low, asynchronous assert
//     sw_rst_req   : one-cycle software reset request
//     wdt_expire   : one-cycle watchdog expiry
//     dom_ready    : per-domain init-done (level)
//     rst_dom_n    : per-domain reset, active-low (registered)
//     sys_ready    : all domains released (registered)
//     rst_cause    : last reset cause, 00 POR / 01 SW / 10 WDT (registered)
//     timeout_err  : sticky per-domain timeout flags, cleared only by rst_in
//     dbg_state_o  : current sequencer state (seq_state_t encoding)
//
//   Handshake: dom_ready[i] is a level, only sampled while domain i is the
//   current stage (released, not yet completed). A domain completes its stage
//   on the first edge where dom_ready[i]=1 or its wait counter has reached 0;
//   dom_ready of domains still held in reset is ignored.
// -----------------------------------------------------------------------------
module reset_sequencer
  import core_config_pkg::*;
#(
  parameter int NUM_DOMAINS   = RST_DOMAINS,
  parameter int HOLD_TICKS    = RST_TICK_CNT,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   sw_rst_req,
  input  logic                   wdt_expire,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] rst_dom_n,
  output logic                   sys_ready,
  output logic [1:0]             rst_cause,
  output logic [NUM_DOMAINS-1:0] timeout_err,
  output logic [1:0]             dbg_state_o
);

  // One counter serves both the hold phase and the per-domain wait.
  localparam int CNT_MAX = max_int(HOLD_TICKS, TIMEOUT_TICKS);
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  // ---------------------------------------------------------------------------
  // Reset synchronization: the FSM leaves reset on the second rising edge
  // after rst_in deasserts, but is cleared immediately when rst_in drops.
  // ---------------------------------------------------------------------------
  logic sync_rst_n;

  rst_sync u_rst_sync (
    .clk_i    (clk),
    .arst_n_i (rst_in),
    .rst_n_o  (sync_rst_n)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seq_state_t             state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [NUM_DOMAINS-1:0] rst_dom_n_q, rst_dom_n_d;
  logic                   sys_ready_q, sys_ready_d;
  rst_cause_t             cause_q,     cause_d;
  logic [NUM_DOMAINS-1:0] terr_q,      terr_d;

  logic reset_req;
  logic stage_done;
  logic cur_ready;

  assign reset_req = sw_rst_req | wdt_expire;
  assign cur_ready = dom_ready[idx_q];
  // The current stage ends on ready or when its wait budget is exhausted.
  assign stage_done = cur_ready | (cnt_q == '0);

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q     <= SEQ_HOLD;
      cnt_q       <= HOLD_LOAD;
      idx_q       <= '0;
      rst_dom_n_q <= '0;
      sys_ready_q <= 1'b0;
      cause_q     <= RST_POR;
      terr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_dom_n_q <= rst_dom_n_d;
      sys_ready_q <= sys_ready_d;
      cause_q     <= cause_d;
      terr_q      <= terr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sys_ready_d = sys_ready_q;
    cause_d     = cause_q;
    terr_d      = terr_q;

    if (reset_req) begin
      // A request preempts whatever the sequencer is doing, including a
      // stage that would time out on this same edge; the watchdog wins
      // the cause when both requests arrive together.
      state_d     = SEQ_HOLD;
      cnt_d       = HOLD_LOAD;
      idx_d       = '0;
      sys_ready_d = 1'b0;
      cause_d     = wdt_expire ? RST_WDT : RST_SW;
    end else begin
      unique case (state_q)
        SEQ_HOLD: begin
          if (cnt_q == '0) begin
            state_d = SEQ_STAGE;
            idx_d   = '0;
            cnt_d   = WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        SEQ_STAGE: begin
          if (stage_done) begin
            if (!cur_ready) begin
              terr_d[idx_q] = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_d     = SEQ_RUN;
              sys_ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = WAIT_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        SEQ_RUN: begin
          // Steady state: everything released until the next reset event.
        end

        default: begin
          state_d = SEQ_HOLD;
          cnt_d   = HOLD_LOAD;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Domain resets follow the next state so they switch on the same edge as
  // the state change: 0..idx released during a stage, all released in RUN.
  always_comb begin
    rst_dom_n_d = '0;
    unique case (state_d)
      SEQ_HOLD: rst_dom_n_d = '0;
      SEQ_STAGE: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          rst_dom_n_d[i] = (i <= int'(idx_d));
        end
      end
      SEQ_RUN: rst_dom_n_d = '1;
      default: rst_dom_n_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign rst_dom_n   = rst_dom_n_q;
  assign sys_ready   = sys_ready_q;
  assign rst_cause   = cause_q;
  assign timeout_err = terr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int N     = 4;
  localparam int HOLD  = 8;
  localparam int TO    = 32;
  localparam int NEVER = 100000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_in;
  logic         sw_rst_req;
  logic         wdt_expire;
  logic [N-1:0] dom_ready;
  logic [N-1:0] rst_dom_n;
  logic         sys_ready;
  logic [1:0]   rst_cause;
  logic [N-1:0] timeout_err;
  logic [1:0]   dbg_state;

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .HOLD_TICKS    (HOLD),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .sw_rst_req  (sw_rst_req),
    .wdt_expire  (wdt_expire),
    .dom_ready   (dom_ready),
    .rst_dom_n   (rst_dom_n),
    .sys_ready   (sys_ready),
    .rst_cause   (rst_cause),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];   // {timeout_err, rst_cause, sys_ready, rst_dom_n}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: counts released domains and remaining waits per phase.
  // ---------------------------------------------------------------------------
  int           m_rel;      // number of domains released (0 = holding)
  int           m_hold;     // hold cycles still to count down
  int           m_wait;     // wait budget left for the current domain
  int           m_sync;     // edges seen since rst_in went high (saturates at 2)
  bit           m_sys;
  logic [1:0]   m_cause;
  logic [N-1:0] m_terr;
  int           age[N];     // cycles a domain has been out of reset
  int           delay[N];   // cycles until a released domain reports ready

  function automatic logic [N-1:0] m_mask();
    if (m_sys) return '1;
    return N'((1 << m_rel) - 1);
  endfunction

  task automatic model_reset();
    m_rel = 0; m_hold = HOLD; m_wait = 0; m_sync = 0;
    m_sys = 0; m_cause = 2'b00; m_terr = '0;
    for (int i = 0; i < N; i++) age[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] mk;
    int d;
    if (!rst_in) begin
      model_reset();
    end else if (m_sync < 2) begin
      m_sync++;
    end else if (sw_rst_req || wdt_expire) begin
      m_rel = 0; m_hold = HOLD; m_sys = 0;
      m_cause = wdt_expire ? 2'b10 : 2'b01;
    end else if (m_rel == 0) begin
      if (m_hold == 0) begin m_rel = 1; m_wait = TO; end
      else m_hold--;
    end else if (!m_sys) begin
      d = m_rel - 1;
      if (dom_ready[d] || m_wait == 0) begin
        if (!dom_ready[d]) m_terr[d] = 1'b1;
        if (m_rel == N) m_sys = 1;
        else begin m_rel++; m_wait = TO; end
      end else begin
        m_wait--;
      end
    end
    mk = m_mask();
    for (int i = 0; i < N; i++) age[i] = mk[i] ? age[i] + 1 : 0;
    exp_q.push_back({m_terr, m_cause, m_sys, mk});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_ready();
    logic [N-1:0] mk;
    mk = m_mask();
    for (int i = 0; i < N; i++)
      dom_ready[i] = mk[i] && (delay[i] != NEVER) && (age[i] >= delay[i]);
  endtask

  task automatic compare_outputs();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("rst_dom_n",   32'(rst_dom_n),   32'(e[3:0]));
    check_eq("sys_ready",   32'(sys_ready),   32'(e[4]));
    check_eq("rst_cause",   32'(rst_cause),   32'(e[6:5]));
    check_eq("timeout_err", 32'(timeout_err), 32'(e[10:7]));
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge,
  // then next-cycle inputs are driven. Request pulses last one cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    drive_ready();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3;
  endtask

  task automatic random_delays();
    for (int i = 0; i < N; i++)
      delay[i] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 40));
  endtask

  task automatic pulse(input logic s, input logic w);
    sw_rst_req = s;
    wdt_expire = w;
    step();
  endtask

  // Power-on reset: rst_in low for 5 cycles, then released; returns the
  // number of edges after release until domain 0 leaves reset.
  task automatic por(output int n);
    rst_in = 1'b0;
    model_reset();
    drive_ready();
    run_cycles(5);
    rst_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rst_dom_n[0]) begin n = i; break; end
    end
  endtask

  task automatic wait_sys_ready(input string tag);
    int k;
    k = 0;
    while (!sys_ready && k < 400) begin step(); k++; end
    check_eq(tag, 32'(sys_ready), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int len;
    rst_in     = 1'b1;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    dom_ready  = '0;
    set_delays(3, 3, 3, 3);
    model_reset();
    #1 rst_in = 1'b0;
    #1;
    check_eq("reset_dom_n",   32'(rst_dom_n), 0);
    check_eq("reset_sys",     32'(sys_ready), 0);
    check_eq("reset_cause",   32'(rst_cause), 0);
    check_eq("reset_terr",    32'(timeout_err), 0);

    // 1. POR with every domain ready 3 cycles after release.
    por(n);
    check_eq("por_release_edge", n, 11);
    wait_sys_ready("por_sys_ready");
    check_eq("por_cause", 32'(rst_cause), 0);
    check_eq("por_terr",  32'(timeout_err), 0);

    // 2. Domain 1 never reports ready: its stage runs out after 33 cycles.
    set_delays(3, NEVER, 3, 3);
    por(n);
    len = 0;
    for (int i = 0; i < 200; i++) begin
      if (rst_dom_n == 4'b0011) len++;
      if (sys_ready) break;
      step();
    end
    check_eq("timeout_stage_len", len, 33);
    wait_sys_ready("timeout_sys_ready");
    check_eq("timeout_terr", 32'(timeout_err), 32'h2);
    run_cycles(3);

    // 3. Software reset from RUN; timeout flag retained.
    set_delays(2, 4, 1, 5);
    pulse(1'b1, 1'b0);
    check_eq("sw_dom_n",  32'(rst_dom_n), 0);
    check_eq("sw_cause",  32'(rst_cause), 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rst_dom_n[0]) begin n = i; break; end
    end
    check_eq("sw_release_delay", n, 9);
    wait_sys_ready("sw_sys_ready");
    check_eq("sw_terr_kept", 32'(timeout_err), 32'h2);

    // 4. Both requests together: watchdog wins.
    pulse(1'b1, 1'b1);
    check_eq("both_cause", 32'(rst_cause), 2);
    wait_sys_ready("both_sys_ready");

    // 5. Watchdog while domain 2 is the current stage.
    set_delays(10, 10, 10, 10);
    pulse(1'b1, 1'b0);
    n = 0;
    while (!(m_rel == 3 && !m_sys) && n < 400) begin step(); n++; end
    check_eq("reach_stage2", 32'(rst_dom_n), 32'h7);
    pulse(1'b0, 1'b1);
    check_eq("wdt_stage_dom_n", 32'(rst_dom_n), 0);
    check_eq("wdt_stage_cause", 32'(rst_cause), 2);
    wait_sys_ready("wdt_stage_sys_ready");

    // Randomized requests and ready delays.
    for (int c = 0; c < 1500; c++) begin
      logic s, w;
      s = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 79) == 0);
      if (s || w) random_delays();
      pulse(s, w);
    end

    // 6. rst_in dropped between edges during a stage, with a timeout recorded.
    set_delays(3, NEVER, 12, 12);
    pulse(1'b0, 1'b1);
    n = 0;
    while (!(m_rel == 3 && !m_sys) && n < 400) begin step(); n++; end
    check_eq("pre_async_terr", 32'(timeout_err[1]), 1);
    @(posedge clk);
    model_edge();
    #2 rst_in = 1'b0;
    #1;
    check_eq("async_dom_n", 32'(rst_dom_n), 0);
    check_eq("async_sys",   32'(sys_ready), 0);
    check_eq("async_terr",  32'(timeout_err), 0);
    check_eq("async_cause", 32'(rst_cause), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    drive_ready();
    set_delays(3, 3, 3, 3);
    por(n);
    check_eq("repor_release_edge", n, 11);
    wait_sys_ready("repor_sys_ready");
    run_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something stalls the stimulus process.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
